// File: rtl/mem_acc_pkg.sv
// Shared encodings for the memory access unit (sizes, memory port codes, FSM states).
// MEM_ACC_MISALIGN_CHK_EN adds the error state used by misalignment checking.
package mem_acc_pkg;

  localparam logic [1:0] SizeByte = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;
  localparam logic [1:0] SizeWord = 2'b10;
  localparam logic [1:0] SizeRsvd = 2'b11;

  localparam logic [1:0] MemIdle  = 2'b00;
  localparam logic [1:0] MemWrite = 2'b01;
  localparam logic [1:0] MemRead  = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StWr,
    StRmwRd,
    StRmwWr
`ifdef MEM_ACC_MISALIGN_CHK_EN
    , StErr
`endif
  } state_e;

  // Copies store data into every lane so the lane mask alone selects the target bytes.
  function automatic logic [31:0] lane_replicate(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      SizeByte: return {4{wdata[7:0]}};
      SizeHalf: return {2{wdata[15:0]}};
      default:  return wdata;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Extracts and extends the addressed byte/half of a memory word, and reports the lane
// mask of that byte/half for merging sub-word stores.
module mem_load_align
  import mem_acc_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  offset_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o,
  output logic [31:0] lane_mask_o
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b      = word_i[{offset_i, 3'b000} +: 8];
    lane_h      = word_i[{offset_i[1], 4'b0000} +: 16];
    data_o      = word_i;
    lane_mask_o = 32'hffff_ffff;
    case (size_i)
      SizeByte: begin
        data_o      = {{24{lane_b[7] & ~unsigned_i}}, lane_b};
        lane_mask_o = 32'h0000_00ff << {offset_i, 3'b000};
      end
      SizeHalf: begin
        data_o      = {{16{lane_h[15] & ~unsigned_i}}, lane_h};
        lane_mask_o = 32'h0000_ffff << {offset_i[1], 4'b0000};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between the EX/MEM latch and a single-port synchronous data memory.
// Define MEM_ACC_MISALIGN_CHK_EN to report misaligned accesses instead of aligning them.
module mem_access_unit
  import mem_acc_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              debug_on,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              misalign_err,
  output logic              stall,
  output logic [1:0]        mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_e            state_q;
  logic [1:0]        size_q;
  logic [1:0]        offset_q;
  logic              unsigned_q;
  logic [31:0]       wdata_q;
  logic              resp_valid_q;
  logic [31:0]       resp_rdata_q;
  logic              misalign_q;
  logic [1:0]        mem_rw_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;

  logic        accept;
  logic [1:0]  offset_in;
  logic [31:0] load_data;
  logic [31:0] lane_mask;

  assign req_ready    = (state_q == StIdle) && !debug_on;
  assign accept       = req_valid && req_ready;
  // The accept cycle holds the pipeline too, so stall covers the whole access latency.
  assign stall        = accept || (state_q != StIdle);
  assign resp_valid   = resp_valid_q;
  assign resp_rdata   = resp_rdata_q;
  assign misalign_err = misalign_q;
  assign mem_rw       = mem_rw_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;

`ifdef MEM_ACC_MISALIGN_CHK_EN
  logic misaligned;

  assign offset_in = req_addr[1:0];

  always_comb begin
    case (req_size)
      SizeByte: misaligned = 1'b0;
      SizeHalf: misaligned = req_addr[0];
      default:  misaligned = |req_addr[1:0];
    endcase
  end
`else
  // Without checking, the unaligned low address bits are simply dropped.
  always_comb begin
    case (req_size)
      SizeByte: offset_in = req_addr[1:0];
      SizeHalf: offset_in = {req_addr[1], 1'b0};
      default:  offset_in = 2'b00;
    endcase
  end
`endif

  mem_load_align u_align (
    .word_i      (mem_rdata),
    .size_i      (size_q),
    .offset_i    (offset_q),
    .unsigned_i  (unsigned_q),
    .data_o      (load_data),
    .lane_mask_o (lane_mask)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      size_q       <= SizeByte;
      offset_q     <= 2'b00;
      unsigned_q   <= 1'b0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      misalign_q   <= 1'b0;
      mem_rw_q     <= MemIdle;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      misalign_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            size_q     <= req_size;
            offset_q   <= offset_in;
            unsigned_q <= req_unsigned;
            wdata_q    <= req_wdata;
            mem_addr_q <= {2'b00, req_addr[ADDR_W-1:2]};
`ifdef MEM_ACC_MISALIGN_CHK_EN
            // Errors respond straight from the accept edge; ERR only holds off new requests.
            if (misaligned) begin
              state_q      <= StErr;
              resp_valid_q <= 1'b1;
              misalign_q   <= 1'b1;
            end else
`endif
            if (!req_store) begin
              state_q  <= StRd;
              mem_rw_q <= MemRead;
            end else if (req_size inside {SizeWord, SizeRsvd}) begin
              state_q     <= StWr;
              mem_rw_q    <= MemWrite;
              mem_wdata_q <= req_wdata;
            end else begin
              state_q  <= StRmwRd;
              mem_rw_q <= MemRead;
            end
          end
        end
        StRd: begin
          state_q      <= StIdle;
          mem_rw_q     <= MemIdle;
          resp_valid_q <= 1'b1;
          resp_rdata_q <= load_data;
        end
        StRmwRd: begin
          state_q     <= StRmwWr;
          mem_rw_q    <= MemWrite;
          mem_wdata_q <= (mem_rdata & ~lane_mask) | (lane_replicate(size_q, wdata_q) & lane_mask);
        end
        StWr, StRmwWr: begin
          state_q      <= StIdle;
          mem_rw_q     <= MemIdle;
          resp_valid_q <= 1'b1;
        end
`ifdef MEM_ACC_MISALIGN_CHK_EN
        StErr: state_q <= StIdle;
`endif
        default: begin
          state_q  <= StIdle;
          mem_rw_q <= MemIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed, table-driven bench for mem_access_unit with a small synchronous memory model.
module tb_mem_access_unit;

  localparam int unsigned AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          debug_on;
  logic          req_valid;
  logic          req_ready;
  logic          req_store;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          misalign_err;
  logic          stall;
  logic [1:0]    mem_rw;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0]   mem [16];
  logic          pl_en = 1'b0;
  logic [3:0]    pl_idx = '0;
  logic [31:0]   pl_val = '0;
  int            rd_cnt = 0;
  int            wr_cnt = 0;
  logic [AW-1:0] last_rd_addr = '0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .debug_on     (debug_on),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_store    (req_store),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .misalign_err (misalign_err),
    .stall        (stall),
    .mem_rw       (mem_rw),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  // Read data is valid throughout the read cycle, so it is there at the closing edge.
  assign mem_rdata = mem[mem_addr[3:0]];

  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_val;
    else if (mem_rw == 2'b01) mem[mem_addr[3:0]] <= mem_wdata;
    if (mem_rw == 2'b01) wr_cnt <= wr_cnt + 1;
    if (mem_rw == 2'b10) begin
      rd_cnt       <= rd_cnt + 1;
      last_rd_addr <= mem_addr;
    end
  end

  typedef struct {
    logic        st;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] init;
    int          lat;
    int          rds;
    int          wrs;
    logic [31:0] rdata;
    logic [31:0] word;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic st, input logic [1:0] sz, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] init, input int lat, input int rds,
                              input int wrs, input logic [31:0] rdata,
                              input logic [31:0] word, input logic err);
    vec_t v;
    v.st = st; v.sz = sz; v.uns = uns; v.addr = addr; v.wd = wd; v.init = init;
    v.lat = lat; v.rds = rds; v.wrs = wrs; v.rdata = rdata; v.word = word; v.err = err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [3:0] idx, input logic [31:0] val);
    pl_en  = 1'b1;
    pl_idx = idx;
    pl_val = val;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  task automatic drive_req(input logic st, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wd);
    req_valid    = 1'b1;
    req_store    = st;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
  endtask

  task automatic scramble_req();
    req_valid    = 1'b0;
    req_store    = 1'($urandom);
    req_size     = 2'($urandom);
    req_unsigned = 1'($urandom);
    req_addr     = $urandom;
    req_wdata    = $urandom;
  endtask

  // Returns cycles from the accept edge to the first negedge with resp_valid, 0 on timeout.
  task automatic wait_resp(output int lat, output int stl);
    lat = 0;
    stl = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = c;
        break;
      end
      if (stall) stl++;
    end
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int lat, stl, r0, w0;
    logic [3:0] idx;
    idx = v.addr[5:2];
    preload(idx, v.init);
    r0 = rd_cnt;
    w0 = wr_cnt;
    drive_req(v.st, v.sz, v.uns, v.addr, v.wd);
    @(negedge clk);
    check($sformatf("v%0d ready", id), 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 scramble_req();
    wait_resp(lat, stl);
    stl = stl + 1;
    check($sformatf("v%0d latency", id), 32'(lat), 32'(v.lat));
    check($sformatf("v%0d rdata", id), resp_rdata, v.rdata);
    check($sformatf("v%0d misalign", id), 32'(misalign_err), 32'(v.err));
    check($sformatf("v%0d stall cycles", id), 32'(stl), 32'(v.lat));
    check($sformatf("v%0d reads", id), 32'(rd_cnt - r0), 32'(v.rds));
    check($sformatf("v%0d writes", id), 32'(wr_cnt - w0), 32'(v.wrs));
    check($sformatf("v%0d word", id), mem[idx], v.word);
    if (v.rds > 0) check($sformatf("v%0d rd addr", id), last_rd_addr, v.addr >> 2);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat, stl, w0, r0, seen;
    rst = 1'b1;
    debug_on = 1'b0;
    req_valid = 1'b0;
    req_store = 1'b0;
    req_size = 2'b00;
    req_unsigned = 1'b0;
    req_addr = '0;
    req_wdata = '0;

    //         st    sz     uns   addr   wdata         init          lat rd wr rdata         word          err
    vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 32'hDEADBEEF, 2, 1, 0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0));
    vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h9, 32'h0, 32'h12348056, 2, 1, 0, 32'hFFFFFF80, 32'h12348056, 1'b0));
    vecs.push_back(mk(1'b0, 2'b00, 1'b1, 32'h9, 32'h0, 32'h12348056, 2, 1, 0, 32'h00000080, 32'h12348056, 1'b0));
    vecs.push_back(mk(1'b0, 2'b01, 1'b0, 32'hE, 32'h0, 32'h80011234, 2, 1, 0, 32'hFFFF8001, 32'h80011234, 1'b0));
    vecs.push_back(mk(1'b0, 2'b01, 1'b1, 32'hE, 32'h0, 32'h80011234, 2, 1, 0, 32'h00008001, 32'h80011234, 1'b0));
    vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h7, 32'h0, 32'h7F000000, 2, 1, 0, 32'h0000007F, 32'h7F000000, 1'b0));
    vecs.push_back(mk(1'b1, 2'b00, 1'b0, 32'h6, 32'h000000AB, 32'h11223344, 3, 1, 1, 32'h0, 32'h11AB3344, 1'b0));
    vecs.push_back(mk(1'b1, 2'b01, 1'b0, 32'hC, 32'hFFFFCAFE, 32'h55667788, 3, 1, 1, 32'h0, 32'h5566CAFE, 1'b0));
    vecs.push_back(mk(1'b1, 2'b01, 1'b0, 32'hE, 32'h0000BEEF, 32'h55667788, 3, 1, 1, 32'h0, 32'hBEEF7788, 1'b0));
    vecs.push_back(mk(1'b1, 2'b00, 1'b0, 32'h13, 32'h12345678, 32'h0, 3, 1, 1, 32'h0, 32'h78000000, 1'b0));
    vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'h4, 32'hCAFEF00D, 32'h0, 2, 0, 1, 32'h0, 32'hCAFEF00D, 1'b0));
    vecs.push_back(mk(1'b0, 2'b11, 1'b1, 32'h8, 32'h0, 32'h01234567, 2, 1, 0, 32'h01234567, 32'h01234567, 1'b0));
`ifdef MEM_ACC_MISALIGN_CHK_EN
    vecs.push_back(mk(1'b0, 2'b01, 1'b0, 32'h3, 32'h0, 32'hA5B6C7D8, 1, 0, 0, 32'h0, 32'hA5B6C7D8, 1'b1));
    vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'h5, 32'h01020304, 32'h0, 1, 0, 0, 32'h0, 32'h0, 1'b1));
    vecs.push_back(mk(1'b1, 2'b01, 1'b0, 32'h1, 32'h0000ABCD, 32'hFFFFFFFF, 1, 0, 0, 32'h0, 32'hFFFFFFFF, 1'b1));
`else
    vecs.push_back(mk(1'b0, 2'b01, 1'b0, 32'h3, 32'h0, 32'hA5B6C7D8, 2, 1, 0, 32'hFFFFA5B6, 32'hA5B6C7D8, 1'b0));
    vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'h5, 32'h01020304, 32'h0, 2, 0, 1, 32'h0, 32'h01020304, 1'b0));
    vecs.push_back(mk(1'b1, 2'b01, 1'b0, 32'h1, 32'h0000ABCD, 32'hFFFFFFFF, 3, 1, 1, 32'h0, 32'hFFFFABCD, 1'b0));
`endif

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset resp_valid", 32'(resp_valid), 32'd0);
    check("reset resp_rdata", resp_rdata, 32'd0);
    check("reset misalign", 32'(misalign_err), 32'd0);
    check("reset stall", 32'(stall), 32'd0);
    check("reset mem_rw", 32'(mem_rw), 32'd0);
    check("reset mem_addr", mem_addr, 32'd0);
    check("reset mem_wdata", mem_wdata, 32'd0);
    check("reset ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Reset during RMW_RD of a halfword store discards the write and the response.
    preload(4'd5, 32'h11111111);
    w0 = wr_cnt;
    drive_req(1'b1, 2'b01, 1'b0, 32'h14, 32'h00002222);
    @(posedge clk);
    #1 scramble_req();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst mid mem_rw", 32'(mem_rw), 32'd0);
    check("rst mid ready", 32'(req_ready), 32'd1);
    check("rst mid stall", 32'(stall), 32'd0);
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      if (resp_valid) seen++;
      @(negedge clk);
    end
    check("rst mid resp", 32'(seen), 32'd0);
    check("rst mid writes", 32'(wr_cnt - w0), 32'd0);
    check("rst mid word", mem[5], 32'h11111111);
    @(posedge clk);
    #1;

    // Back-to-back SW then LW with req_valid held high.
    drive_req(1'b1, 2'b10, 1'b0, 32'h0, 32'h00000005);
    @(posedge clk);
    #1 drive_req(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    wait_resp(lat, stl);
    check("b2b store latency", 32'(lat), 32'd2);
    check("b2b ready with resp", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 scramble_req();
    wait_resp(lat, stl);
    check("b2b load latency", 32'(lat), 32'd2);
    check("b2b load rdata", resp_rdata, 32'h00000005);
    @(posedge clk);
    #1;

    // debug_on blocks acceptance.
    r0 = rd_cnt;
    debug_on = 1'b1;
    drive_req(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (req_ready || resp_valid || stall) seen++;
    end
    check("debug blocks", 32'(seen), 32'd0);
    check("debug no reads", 32'(rd_cnt - r0), 32'd0);
    @(posedge clk);
    #1 scramble_req();
    debug_on = 1'b0;

    // debug_on rising mid-operation does not abort a sub-word store.
    preload(4'd2, 32'h0);
    drive_req(1'b1, 2'b00, 1'b0, 32'h8, 32'h00000011);
    @(posedge clk);
    #1 scramble_req();
    debug_on = 1'b1;
    wait_resp(lat, stl);
    check("debug mid latency", 32'(lat), 32'd3);
    check("debug mid word", mem[2], 32'h00000011);
    debug_on = 1'b0;
    @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
